gray2bin_reg: RTL and testbench

//   Gray-code to binary converter with a registered output stage.
//   b[MSB] = g[MSB]; b[i] = b[i+1] ^ g[i] (prefix XOR from MSB down).

---
 rtl/gray_pkg.sv | 20 ++
 rtl/gray2bin_comb.sv | 17 +
 rtl/gray2bin_reg.sv | 33 +++
 tb/tb_gray2bin_reg.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared definitions for the Gray/binary converters: the default code width and
// loop-based reference conversions in both directions.
package gray_pkg;

    localparam int DEFAULT_GRAY_W = 4;

    function automatic logic [DEFAULT_GRAY_W-1:0] gray2bin(input logic [DEFAULT_GRAY_W-1:0] g);
        logic [DEFAULT_GRAY_W-1:0] b;
        b[DEFAULT_GRAY_W-1] = g[DEFAULT_GRAY_W-1];
        for (int i = DEFAULT_GRAY_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [DEFAULT_GRAY_W-1:0] bin2gray(input logic [DEFAULT_GRAY_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/gray2bin_comb.sv
// Combinational Gray-to-binary conversion: each binary bit is the XOR of all
// Gray bits from the MSB down to that position.
module gray2bin_comb
    import gray_pkg::*;
#(
    parameter int WIDTH = DEFAULT_GRAY_W
) (
    input  logic [WIDTH-1:0] g,
    output logic [WIDTH-1:0] b
);

    // Each bit is reduced independently so there is no ripple through b itself.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign b[i] = ^g[WIDTH-1:i];
    end

endmodule

// File: rtl/gray2bin_reg.sv
// Gray-to-binary converter with a one-cycle registered output and valid flag,
// plus a zero-latency combinational copy of the conversion.
module gray2bin_reg
    import gray_pkg::*;
#(
    parameter int WIDTH = DEFAULT_GRAY_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] g,
    input  logic             in_valid,
    output logic [WIDTH-1:0] b_comb,
    output logic [WIDTH-1:0] b,
    output logic             out_valid
);

    gray2bin_comb #(.WIDTH(WIDTH)) u_conv (
        .g (g),
        .b (b_comb)
    );

    // Data only loads on valid, so an undriven g while idle never reaches b.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b         <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) b <= b_comb;
        end
    end

endmodule

// File: tb/tb_gray2bin_reg.sv
// Directed and randomized checks of the registered Gray-to-binary converter.
module tb_gray2bin_reg;
    import gray_pkg::*;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] g;
    logic         in_valid;
    logic [W-1:0] b_comb;
    logic [W-1:0] b;
    logic         out_valid;

    int checks   = 0;
    int failures = 0;

    gray2bin_reg #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .g         (g),
        .in_valid  (in_valid),
        .b_comb    (b_comb),
        .b         (b),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] g;
        logic         v;
        logic         chk_comb;
        logic [W-1:0] exp_comb;
        logic [W-1:0] exp_b;
        logic         exp_ov;
    } vec_t;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b expected=%b", name, act, exp);
        end
    endtask

    vec_t vecs[14];
    logic [W-1:0] mb;
    logic         mov;

    initial begin
        // hand-computed vectors: drive at negedge, comb checked #1 later,
        // registered outputs checked at the following negedge
        vecs[0]  = '{4'b0100, 1'b1, 1'b1, 4'b0111, 4'b0111, 1'b1};
        vecs[1]  = '{4'b0001, 1'b1, 1'b1, 4'b0001, 4'b0001, 1'b1};
        vecs[2]  = '{4'b1001, 1'b1, 1'b1, 4'b1110, 4'b1110, 1'b1};
        vecs[3]  = '{4'b0011, 1'b1, 1'b1, 4'b0010, 4'b0010, 1'b1};
        vecs[4]  = '{4'b1101, 1'b1, 1'b1, 4'b1001, 4'b1001, 1'b1};
        vecs[5]  = '{4'b0101, 1'b1, 1'b1, 4'b0110, 4'b0110, 1'b1};
        vecs[6]  = '{4'b0010, 1'b1, 1'b1, 4'b0011, 4'b0011, 1'b1};
        vecs[7]  = '{4'b1101, 1'b1, 1'b1, 4'b1001, 4'b1001, 1'b1};
        vecs[8]  = '{4'b0000, 1'b0, 1'b1, 4'b0000, 4'b1001, 1'b0};
        vecs[9]  = '{4'b1111, 1'b1, 1'b1, 4'b1010, 4'b1010, 1'b1};
        vecs[10] = '{4'bxxxx, 1'b0, 1'b0, 4'b0000, 4'b1010, 1'b0};
        vecs[11] = '{4'b1000, 1'b1, 1'b1, 4'b1111, 4'b1111, 1'b1};
        vecs[12] = '{4'b0000, 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b1};
        vecs[13] = '{4'b0110, 1'b0, 1'b1, 4'b0100, 4'b0000, 1'b0};

        rst = 1'b1; g = '0; in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_b", b, 4'b0000);
        chk("reset_ov", {3'b0, out_valid}, 4'b0000);
        rst = 1'b0;

        // async reset mid-cycle, no edge in between
        g = 4'b1101; in_valid = 1'b1;
        @(negedge clk);
        chk("pre_rst_b", b, 4'b1001);
        chk("pre_rst_ov", {3'b0, out_valid}, 4'b0001);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_b", b, 4'b0000);
        chk("async_rst_ov", {3'b0, out_valid}, 4'b0000);
        chk("comb_ignores_rst", b_comb, 4'b1001);
        // hold reset across an edge with in_valid=1, then release idle
        @(negedge clk);
        chk("rst_hold_b", b, 4'b0000);
        chk("rst_hold_ov", {3'b0, out_valid}, 4'b0000);
        rst = 1'b0; in_valid = 1'b0; g = 4'b0011;
        @(negedge clk);
        chk("post_rst_idle_ov", {3'b0, out_valid}, 4'b0000);
        chk("post_rst_idle_b", b, 4'b0000);

        for (int i = 0; i < 14; i++) begin
            g = vecs[i].g; in_valid = vecs[i].v;
            #1;
            if (vecs[i].chk_comb) chk($sformatf("vec%0d_comb", i), b_comb, vecs[i].exp_comb);
            @(negedge clk);
            chk($sformatf("vec%0d_b", i), b, vecs[i].exp_b);
            chk($sformatf("vec%0d_ov", i), {3'b0, out_valid}, {3'b0, vecs[i].exp_ov});
        end

        // exhaustive sweep with round trip
        for (int i = 0; i < 16; i++) begin
            g = 4'(i); in_valid = 1'b1;
            @(negedge clk);
            chk($sformatf("sweep%0d_b", i), b, gray2bin(4'(i)));
            chk($sformatf("sweep%0d_rt", i), bin2gray(b), 4'(i));
        end

        // random valid and async reset pulses against a cycle model
        mb = b; mov = out_valid;
        for (int i = 0; i < 300; i++) begin
            int kind;
            logic [W-1:0] gs;
            logic vs;
            gs = 4'($urandom_range(0, 15));
            vs = 1'($urandom_range(0, 1));
            kind = $urandom_range(0, 9);
            g = gs; in_valid = vs;
            if (kind == 0) begin
                // short pulse entirely before the edge
                #2 rst = 1'b1;
                #1 chk($sformatf("rnd%0d_pulse_b", i), b, 4'b0000);
                chk($sformatf("rnd%0d_pulse_ov", i), {3'b0, out_valid}, 4'b0000);
                rst = 1'b0;
                mov = vs;
                mb  = vs ? gray2bin(gs) : 4'b0000;
                @(negedge clk);
            end else if (kind == 1) begin
                // pulse spanning the edge discards the in-flight value
                #2 rst = 1'b1;
                mov = 1'b0; mb = '0;
                @(negedge clk);
                rst = 1'b0;
            end else begin
                if (vs) mb = gray2bin(gs);
                mov = vs;
                @(negedge clk);
            end
            chk($sformatf("rnd%0d_ov", i), {3'b0, out_valid}, {3'b0, mov});
            chk($sformatf("rnd%0d_b", i), b, mb);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
